// File: rtl/uart_pkg.sv
// Shared UART receive-path types and helpers.
// Entry layout is {stop_err, par_err, data}.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int ERR_CNT_W   = 8;

  typedef struct packed {
    logic                   stop_err;
    logic                   par_err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

  localparam int ENTRY_W = $bits(uart_rx_entry_t);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    logic [ERR_CNT_W-1:0] r;
    r = (&v) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Head entry is read combinationally from the array.
module uart_sync_fifo #(
  parameter  int WIDTH  = 10,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A full FIFO still accepts a write when the head leaves that cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one entry per VALID_RX rising edge,
// with error tagging, sticky overflow and saturating error count.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W       = 8,
  parameter  int DEPTH        = 16,
  parameter  bit DROP_ERRORED = 1'b0,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_W-1:0]    RXDATA,
  input  logic                 VALID_RX,
  input  logic                 PARITY_ERROR,
  input  logic                 STOP_ERROR,
  input  logic                 flush,
  input  logic                 clr_overflow,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_par_err,
  output logic                 rd_stop_err,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int EW = DATA_W + 2;

  logic          valid_q;
  logic          push_req;
  logic          err;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign push_req = VALID_RX & ~valid_q;
  assign err      = PARITY_ERROR | STOP_ERROR;
  assign push     = push_req & ~(DROP_ERRORED & err) & ~flush;
  assign pop      = rd_valid & rd_ready & ~flush;
  assign ovf_set  = push & full & ~pop;
  assign wr_entry = {STOP_ERROR, PARITY_ERROR, RXDATA};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q  <= 1'b0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      valid_q <= VALID_RX;
      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      // Errored frames are counted even when flushed or dropped.
      if (push_req & err)    err_cnt  <= sat_inc(err_cnt);
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign rd_valid    = ~empty;
  assign rd_data     = rd_entry[DATA_W-1:0];
  assign rd_par_err  = rd_entry[DATA_W];
  assign rd_stop_err = rd_entry[DATA_W+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo, keep and drop variants
// driven by shared stimulus against a queue-based model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rxdata;
  logic       valid_rx;
  logic       par_e;
  logic       stop_e;
  logic       flush;
  logic       clr_ovf;
  logic       rd_ready;

  logic [1:0] rd_valid;
  logic [1:0] rd_par;
  logic [1:0] rd_stop;
  logic [1:0] full_o;
  logic [1:0] empty_o;
  logic [1:0] ovf_o;
  logic [7:0] rd_data [2];
  logic [4:0] cnt_o   [2];
  logic [7:0] errc_o  [2];

  int total = 0;
  int pass  = 0;

  uart_rx_entry_t mq [2][$];
  logic           m_ovf [2];
  int             m_err;
  logic           m_vq;

  always #10 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_ERRORED(1'b0)) dut_keep (
    .CLK(clk), .RST(rst_n), .RXDATA(rxdata), .VALID_RX(valid_rx),
    .PARITY_ERROR(par_e), .STOP_ERROR(stop_e), .flush(flush),
    .clr_overflow(clr_ovf), .rd_ready(rd_ready),
    .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .rd_par_err(rd_par[0]), .rd_stop_err(rd_stop[0]),
    .count(cnt_o[0]), .full(full_o[0]), .empty(empty_o[0]),
    .overflow(ovf_o[0]), .err_cnt(errc_o[0])
  );

  uart_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .DROP_ERRORED(1'b1)) dut_drop (
    .CLK(clk), .RST(rst_n), .RXDATA(rxdata), .VALID_RX(valid_rx),
    .PARITY_ERROR(par_e), .STOP_ERROR(stop_e), .flush(flush),
    .clr_overflow(clr_ovf), .rd_ready(rd_ready),
    .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .rd_par_err(rd_par[1]), .rd_stop_err(rd_stop[1]),
    .count(cnt_o[1]), .full(full_o[1]), .empty(empty_o[1]),
    .overflow(ovf_o[1]), .err_cnt(errc_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
    end
    m_err = 0;
    m_vq  = 1'b0;
  endtask

  // Called exactly at a rising edge, before stimulus moves.
  task automatic model_update();
    bit req, err, pop, push, lost;
    if (!rst_n) return;
    req  = valid_rx && !m_vq;
    m_vq = valid_rx;
    err  = par_e || stop_e;
    if (req && err && m_err < 255) m_err++;
    for (int i = 0; i < 2; i++) begin
      pop  = (mq[i].size() > 0) && rd_ready && !flush;
      push = req && !flush && !(i == 1 && err);
      lost = push && (mq[i].size() == DEPTH) && !pop;
      if (flush) mq[i].delete();
      else begin
        if (pop) void'(mq[i].pop_front());
        if (push && !lost) mq[i].push_back('{stop_e, par_e, rxdata});
      end
      if (lost) m_ovf[i] = 1'b1;
      else if (clr_ovf) m_ovf[i] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    valid_rx = 0; par_e = 0; stop_e = 0;
    flush = 0; clr_ovf = 0; rd_ready = 0; rxdata = '0;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe,
                       input logic se, input int hold);
    rxdata = d; par_e = pe; stop_e = se; valid_rx = 1;
    repeat (hold) tick();
    valid_rx = 0; par_e = 0; stop_e = 0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rd_valid"}, rd_valid[i], 0);
      chk({tag, "_count"},    cnt_o[i],    0);
      chk({tag, "_empty"},    empty_o[i],  1);
      chk({tag, "_full"},     full_o[i],   0);
      chk({tag, "_overflow"}, ovf_o[i],    0);
      chk({tag, "_err_cnt"},  errc_o[i],   0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;
  endtask

  task automatic drain(input int n);
    rd_ready = 1;
    repeat (n) tick();
    rd_ready = 0;
  endtask

  // Monitor: compare DUT head and status with the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("mon%0d_valid", i), rd_valid[i], mq[i].size() > 0);
          chk($sformatf("mon%0d_count", i), cnt_o[i], mq[i].size());
          chk($sformatf("mon%0d_full", i), full_o[i], mq[i].size() == DEPTH);
          chk($sformatf("mon%0d_empty", i), empty_o[i], mq[i].size() == 0);
          chk($sformatf("mon%0d_ovf", i), ovf_o[i], m_ovf[i]);
          chk($sformatf("mon%0d_errc", i), errc_o[i], m_err);
          if (mq[i].size() > 0) begin
            chk($sformatf("mon%0d_data", i), rd_data[i], mq[i][0].data);
            chk($sformatf("mon%0d_par", i), rd_par[i], mq[i][0].par_err);
            chk($sformatf("mon%0d_stop", i), rd_stop[i], mq[i][0].stop_err);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst_n = 1;
    model_reset();
    do_reset();

    // Held VALID_RX gives exactly one entry.
    frame(8'hAA, 0, 0, 3);
    chk("t1_count", cnt_o[0], 1);
    chk("t1_data", rd_data[0], 8'hAA);
    drain(1);
    chk("t1_empty", empty_o[0], 1);

    // Overflow on the 17th frame, ordered drain, clear.
    for (int k = 0; k < 17; k++) frame(8'(k), 0, 0, 1);
    chk("t2_full", full_o[0], 1);
    chk("t2_count", cnt_o[0], 16);
    chk("t2_ovf", ovf_o[0], 1);
    rd_ready = 1;
    for (int k = 0; k < 16; k++) begin
      chk("t2_order", rd_data[0], k);
      tick();
    end
    rd_ready = 0;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("t2_clr", ovf_o[0], 0);

    // Push and pop together on a full FIFO.
    for (int k = 0; k < 16; k++) frame(8'(k), 0, 0, 1);
    rxdata = 8'h55; valid_rx = 1; rd_ready = 1;
    tick();
    valid_rx = 0; rd_ready = 0;
    tick();
    chk("t3_count", cnt_o[0], 16);
    chk("t3_ovf", ovf_o[0], 0);
    chk("t3_head", rd_data[0], 8'h01);
    drain(15);
    chk("t3_last", rd_data[0], 8'h55);
    drain(1);

    // Errored frame: kept vs dropped.
    do_reset();
    frame(8'hF0, 1, 0, 1);
    chk("t4_keep_par", rd_par[0], 1);
    chk("t4_keep_data", rd_data[0], 8'hF0);
    chk("t4_drop_empty", empty_o[1], 1);
    chk("t4_errc_keep", errc_o[0], 1);
    chk("t4_errc_drop", errc_o[1], 1);
    drain(1);

    // Flush with a coincident frame edge.
    for (int k = 0; k < 5; k++) frame(8'(8'h40 + k), 0, 0, 1);
    rxdata = 8'h77; valid_rx = 1; flush = 1;
    tick();
    flush = 0; valid_rx = 0;
    chk("t5_count", cnt_o[0], 0);
    chk("t5_empty", empty_o[0], 1);
    tick();
    chk("t5_ovf", ovf_o[0], 0);
    frame(8'h3C, 0, 0, 1);
    chk("t5_sole_count", cnt_o[0], 1);
    chk("t5_sole_data", rd_data[0], 8'h3C);
    drain(1);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0) valid_rx = ~valid_rx;
      rxdata   = 8'($urandom);
      par_e    = ($urandom_range(0, 7) == 0);
      stop_e   = ($urandom_range(0, 7) == 0);
      rd_ready = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      clr_ovf  = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a drain with 7 left.
    do_reset();
    for (int k = 0; k < 9; k++) frame(8'(8'h80 + k), 0, 0, 1);
    drain(2);
    chk("t6_pre_count", cnt_o[0], 7);
    rd_ready = 1;
    tick();
    #3;
    rst_n = 0;
    model_reset();
    #1;
    chk_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;

    // Error counter saturation.
    for (int k = 0; k < 300; k++)
      frame(8'($urandom), 1, 1'($urandom), 1);
    chk("t6_sat_keep", errc_o[0], 8'hFF);
    chk("t6_sat_drop", errc_o[1], 8'hFF);
    chk("t6_drop_empty", empty_o[1], 1);
    tick();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
